// File: rtl/l1_cache_pkg.sv
// Shared types and line-geometry helpers for the L1 refill/writeback engine.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    L2CmdRd = 2'b00,
    L2CmdWr = 2'b01
  } l2_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StWbRead,
    StWbReq,
    StWbData,
    StWbResp,
    StRdReq,
    StRdData,
    StDone
  } state_e;

  localparam int unsigned WordBytes = 4;

  function automatic int unsigned line_bytes(input int unsigned words);
    return words * WordBytes;
  endfunction

  function automatic int unsigned off_width(input int unsigned words);
    return $clog2(words * WordBytes);
  endfunction

endpackage

// File: rtl/l1_line_buffer.sv
// Victim line staging buffer: one write port, one combinational read port.
module l1_line_buffer #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [$clog2(LINE_WORDS)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(LINE_WORDS)-1:0] ridx,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/l1_refill_engine.sv
// L1 miss handler: optional dirty-victim writeback, then line fetch from L2
// written beat-by-beat into the L1 data RAM, with done/err back to the controller.
module l1_refill_engine
  import l1_cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS    = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned L2_CMND_WIDTH = 2,
  parameter int unsigned L2_SIZE_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_val,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  input  logic                          miss_dirty,
  input  logic [ADDR_WIDTH-1:0]         miss_victim_addr,
  output logic                          miss_ack,
  output logic                          vic_ren,
  output logic [$clog2(LINE_WORDS)-1:0] vic_idx,
  input  logic [DATA_WIDTH-1:0]         vic_rdata,
  output logic                          fill_wen,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_WIDTH-1:0]         fill_wdata,
  output logic                          req_val,
  output logic                          req_nc,
  output logic [L2_CMND_WIDTH-1:0]      req_cmd,
  output logic [L2_SIZE_WIDTH-1:0]      req_size,
  output logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          req_wdata_val,
  output logic [DATA_WIDTH-1:0]         req_wdata,
  output logic [DATA_WIDTH/8-1:0]       req_wstrb,
  input  logic                          req_rdy,
  input  logic                          resp_val,
  input  logic                          resp_err,
  input  logic                          resp_rdata_val,
  input  logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = off_width(LINE_WORDS);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(LINE_WORDS);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(LINE_WORDS - 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic                  vic_vld;
  logic                  err_flag;
  logic [ADDR_WIDTH-1:0] miss_line;
  logic [ADDR_WIDTH-1:0] vic_line;

  logic                  buf_wen;
  logic [IDX_W-1:0]      buf_ridx;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic                  rd_beat;
  logic                  rd_keep;
  logic [CNT_W-1:0]      beats_now;
  logic                  rd_err;

  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // Gated with rst so every output reads zero while reset is held.
  assign miss_ack  = (state == StIdle) & miss_val & ~rst;

  assign buf_wen   = (state == StWbRead) & vic_vld;
  // Look one word ahead so req_wdata can be reloaded on the accepting edge.
  assign buf_ridx  = (state == StWbData) ? cnt[IDX_W-1:0] + IDX_W'(1) : '0;

  assign rd_beat   = (state == StRdData) & resp_rdata_val;
  assign rd_keep   = rd_beat & ~cnt[IDX_W];
  assign beats_now = cnt + CNT_W'(rd_beat);
  assign rd_err    = resp_err | err_flag | (beats_now != CntFull);

  assign fill_wen   = rd_keep;
  assign fill_idx   = rd_keep ? cnt[IDX_W-1:0] : '0;
  assign fill_wdata = rd_keep ? resp_rdata : '0;

  assign req_nc    = 1'b0;
  assign req_size  = req_val ? L2_SIZE_WIDTH'(OFF_W) : '0;
  assign req_wstrb = {(DATA_WIDTH/8){req_wdata_val}};

  l1_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .wen   (buf_wen),
    .widx  (cnt[IDX_W-1:0]),
    .wdata (vic_rdata),
    .ridx  (buf_ridx),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= '0;
      vic_vld       <= 1'b0;
      err_flag      <= 1'b0;
      miss_line     <= '0;
      vic_line      <= '0;
      vic_ren       <= 1'b0;
      vic_idx       <= '0;
      req_val       <= 1'b0;
      req_cmd       <= '0;
      req_addr      <= '0;
      req_wdata_val <= 1'b0;
      req_wdata     <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (miss_val) begin
            miss_line <= line_addr(miss_addr);
            vic_line  <= line_addr(miss_victim_addr);
            cnt       <= '0;
            err_flag  <= 1'b0;
            if (miss_dirty) begin
              state   <= StWbRead;
              vic_ren <= 1'b1;
              vic_idx <= '0;
            end else begin
              state    <= StRdReq;
              req_val  <= 1'b1;
              req_cmd  <= L2_CMND_WIDTH'(L2CmdRd);
              req_addr <= line_addr(miss_addr);
            end
          end
        end
        StWbRead: begin
          // vic_vld marks the cycle the RAM returns the word requested last cycle.
          vic_vld <= vic_ren;
          if (vic_ren) begin
            if (vic_idx == IdxLast) begin
              vic_ren <= 1'b0;
              vic_idx <= '0;
            end else begin
              vic_idx <= vic_idx + IDX_W'(1);
            end
          end
          if (vic_vld) begin
            if (cnt == CntLast) begin
              cnt      <= '0;
              state    <= StWbReq;
              req_val  <= 1'b1;
              req_cmd  <= L2_CMND_WIDTH'(L2CmdWr);
              req_addr <= vic_line;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        StWbReq: begin
          if (req_rdy) begin
            req_val       <= 1'b0;
            req_cmd       <= '0;
            req_addr      <= '0;
            req_wdata_val <= 1'b1;
            req_wdata     <= buf_rdata;
            state         <= StWbData;
          end
        end
        StWbData: begin
          if (req_rdy) begin
            if (cnt == CntLast) begin
              req_wdata_val <= 1'b0;
              req_wdata     <= '0;
              cnt           <= '0;
              state         <= StWbResp;
            end else begin
              cnt       <= cnt + CNT_W'(1);
              req_wdata <= buf_rdata;
            end
          end
        end
        StWbResp: begin
          if (resp_val) begin
            if (resp_err) begin
              err_flag <= 1'b1;
              done     <= 1'b1;
              err      <= 1'b1;
              state    <= StDone;
            end else begin
              req_val  <= 1'b1;
              req_cmd  <= L2_CMND_WIDTH'(L2CmdRd);
              req_addr <= miss_line;
              state    <= StRdReq;
            end
          end
        end
        StRdReq: begin
          if (req_rdy) begin
            req_val  <= 1'b0;
            req_cmd  <= '0;
            req_addr <= '0;
            cnt      <= '0;
            state    <= StRdData;
          end
        end
        StRdData: begin
          // The counter saturates at a full line; surplus beats only mark the error.
          if (rd_keep) begin
            cnt <= beats_now;
          end else if (rd_beat) begin
            err_flag <= 1'b1;
          end
          if (resp_val) begin
            done     <= 1'b1;
            err      <= rd_err;
            err_flag <= rd_err;
            state    <= StDone;
          end
        end
        StDone: begin
          done     <= 1'b0;
          err      <= 1'b0;
          err_flag <= 1'b0;
          cnt      <= '0;
          state    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_refill_engine.sv
// Directed plus randomized checks of l1_refill_engine against a transaction-level model.
module tb_l1_refill_engine;

  localparam int LW = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          miss_val;
  logic [AW-1:0] miss_addr;
  logic          miss_dirty;
  logic [AW-1:0] miss_victim_addr;
  logic          miss_ack;
  logic          vic_ren;
  logic [1:0]    vic_idx;
  logic [DW-1:0] vic_rdata;
  logic          fill_wen;
  logic [1:0]    fill_idx;
  logic [DW-1:0] fill_wdata;
  logic          req_val;
  logic          req_nc;
  logic [1:0]    req_cmd;
  logic [2:0]    req_size;
  logic [AW-1:0] req_addr;
  logic          req_wdata_val;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          req_rdy;
  logic          resp_val;
  logic          resp_err;
  logic          resp_rdata_val;
  logic [DW-1:0] resp_rdata;
  logic          done;
  logic          err;

  l1_refill_engine #(
    .LINE_WORDS    (LW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .L2_CMND_WIDTH (2),
    .L2_SIZE_WIDTH (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_val         (miss_val),
    .miss_addr        (miss_addr),
    .miss_dirty       (miss_dirty),
    .miss_victim_addr (miss_victim_addr),
    .miss_ack         (miss_ack),
    .vic_ren          (vic_ren),
    .vic_idx          (vic_idx),
    .vic_rdata        (vic_rdata),
    .fill_wen         (fill_wen),
    .fill_idx         (fill_idx),
    .fill_wdata       (fill_wdata),
    .req_val          (req_val),
    .req_nc           (req_nc),
    .req_cmd          (req_cmd),
    .req_size         (req_size),
    .req_addr         (req_addr),
    .req_wdata_val    (req_wdata_val),
    .req_wdata        (req_wdata),
    .req_wstrb        (req_wstrb),
    .req_rdy          (req_rdy),
    .resp_val         (resp_val),
    .resp_err         (resp_err),
    .resp_rdata_val   (resp_rdata_val),
    .resp_rdata       (resp_rdata),
    .done             (done),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;

  logic [1:0]    rq_cmd[$];
  logic [AW-1:0] rq_addr[$];
  logic [DW-1:0] wd_q[$];
  int            fi_q[$];
  logic [DW-1:0] fd_q[$];
  logic          done_seen;
  logic          err_seen;
  int            ack_cnt, ack_cyc, req1_cyc, fill1_cyc, done_cyc;

  logic [DW-1:0] vic_mem[LW];
  logic [DW-1:0] bd[8];

  logic          pend_ren;
  logic [1:0]    pend_idx;
  logic          prev_rv, prev_wv, prev_rdy;
  logic [1:0]    prev_cmd;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({miss_ack, vic_ren, vic_idx, fill_wen, fill_idx, fill_wdata, req_val, req_nc,
                 req_cmd, req_size, req_addr, req_wdata_val, req_wdata, req_wstrb, done, err});
  endfunction

  task automatic clear_logs();
    rq_cmd.delete();
    rq_addr.delete();
    wd_q.delete();
    fi_q.delete();
    fd_q.delete();
    done_seen = 1'b0;
    err_seen  = 1'b0;
    ack_cnt   = 0;
    ack_cyc   = -1;
    req1_cyc  = -1;
    fill1_cyc = -1;
    done_cyc  = -1;
  endtask

  // Observe one cycle at the falling edge, then return just after the next rising edge.
  task automatic sample();
    @(negedge clk);
    cyc++;
    if (miss_ack) begin
      ack_cnt++;
      if (ack_cyc < 0) ack_cyc = cyc;
    end
    if (req_val && req1_cyc < 0) req1_cyc = cyc;
    if (req_val || req_wdata_val)
      check("req_exclusive", 128'(req_val & req_wdata_val), 128'(0));
    if (prev_rv && !prev_rdy)
      check("req_hold", 128'({req_val, req_cmd, req_addr}), 128'({1'b1, prev_cmd, prev_addr}));
    if (prev_wv && !prev_rdy)
      check("wdata_hold", 128'({req_wdata_val, req_wdata}), 128'({1'b1, prev_wd}));
    if (req_wdata_val) check("wstrb", 128'(req_wstrb), 128'(4'hf));
    if (req_val && req_rdy) begin
      rq_cmd.push_back(req_cmd);
      rq_addr.push_back(req_addr);
      check("req_size", 128'(req_size), 128'(3'd4));
      check("req_nc", 128'(req_nc), 128'(0));
    end
    if (req_wdata_val && req_rdy) wd_q.push_back(req_wdata);
    if (fill_wen) begin
      if (fill1_cyc < 0) fill1_cyc = cyc;
      fi_q.push_back(int'(fill_idx));
      fd_q.push_back(fill_wdata);
    end
    if (done) begin
      done_seen = 1'b1;
      err_seen  = err;
      done_cyc  = cyc;
    end
    pend_ren  = vic_ren;
    pend_idx  = vic_idx;
    prev_rv   = req_val;
    prev_wv   = req_wdata_val;
    prev_rdy  = req_rdy;
    prev_cmd  = req_cmd;
    prev_addr = req_addr;
    prev_wd   = req_wdata;
    @(posedge clk);
    #1;
    vic_rdata = pend_ren ? vic_mem[pend_idx] : $urandom();
  endtask

  // rdy_mode: 0 always ready, 1 alternating, 2 random stalls with gapped beats.
  task automatic do_miss(input logic [AW-1:0] a, input logic dirty, input logic [AW-1:0] va,
                         input int nbeats, input logic wb_err, input logic fin_err,
                         input int rdy_mode, input logic hold, input logic timing);
    int            bsent;
    logic          wb_sent, rd_sent, eerr;
    logic [1:0]    ecmd[$];
    logic [AW-1:0] eaddr[$];
    int            nfill;
    clear_logs();
    foreach (vic_mem[i]) vic_mem[i] = $urandom();
    foreach (bd[i]) bd[i] = $urandom();
    miss_addr        = a;
    miss_victim_addr = va;
    miss_dirty       = dirty;
    miss_val         = 1'b1;
    bsent   = 0;
    wb_sent = 1'b0;
    rd_sent = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (c > 0 && !hold) begin
        miss_val         = 1'b0;
        miss_addr        = AW'($urandom());
        miss_victim_addr = AW'($urandom());
        miss_dirty       = 1'($urandom());
      end
      case (rdy_mode)
        0:       req_rdy = 1'b1;
        1:       req_rdy = (c % 2 == 0);
        default: req_rdy = ($urandom_range(99) >= 30);
      endcase
      resp_val       = 1'b0;
      resp_err       = 1'b0;
      resp_rdata_val = 1'b0;
      resp_rdata     = $urandom();
      if (dirty && !wb_sent && wd_q.size() == LW) begin
        resp_val = 1'b1;
        resp_err = wb_err;
        wb_sent  = 1'b1;
      end else if (!rd_sent && rq_cmd.size() > 0 && rq_cmd[rq_cmd.size()-1] == 2'b00) begin
        if (nbeats == 0) begin
          resp_val = 1'b1;
          resp_err = fin_err;
          rd_sent  = 1'b1;
        end else if (rdy_mode != 2 || $urandom_range(3) != 0) begin
          resp_rdata_val = 1'b1;
          resp_rdata     = bd[bsent];
          bsent++;
          if (bsent == nbeats) begin
            resp_val = 1'b1;
            resp_err = fin_err;
            rd_sent  = 1'b1;
          end
        end
      end
      sample();
    end
    miss_val       = 1'b0;
    resp_val       = 1'b0;
    resp_err       = 1'b0;
    resp_rdata_val = 1'b0;
    check("done_seen", 128'(done_seen), 128'(1));
    sample();
    check("ack_count", 128'(ack_cnt), 128'(1));

    if (dirty) begin
      ecmd.push_back(2'b01);
      eaddr.push_back(va & 16'hfff0);
    end
    if (!(dirty && wb_err)) begin
      ecmd.push_back(2'b00);
      eaddr.push_back(a & 16'hfff0);
    end
    nfill = (dirty && wb_err) ? 0 : ((nbeats < LW) ? nbeats : LW);
    eerr  = (dirty && wb_err) ? 1'b1 : (fin_err || nbeats != LW);

    check("req_count", 128'(rq_cmd.size()), 128'(ecmd.size()));
    for (int i = 0; i < rq_cmd.size() && i < ecmd.size(); i++) begin
      check("req_cmd", 128'(rq_cmd[i]), 128'(ecmd[i]));
      check("req_addr", 128'(rq_addr[i]), 128'(eaddr[i]));
    end
    check("wb_beats", 128'(wd_q.size()), 128'(dirty ? LW : 0));
    for (int i = 0; i < wd_q.size() && i < LW; i++)
      check("wb_data", 128'(wd_q[i]), 128'(vic_mem[i]));
    check("fill_count", 128'(fi_q.size()), 128'(nfill));
    for (int i = 0; i < fi_q.size() && i < nfill; i++) begin
      check("fill_idx", 128'(fi_q[i]), 128'(i));
      check("fill_data", 128'(fd_q[i]), 128'(bd[i]));
    end
    check("done_err", 128'(err_seen), 128'(eerr));
    if (timing) begin
      check("t_req", 128'(req1_cyc - ack_cyc), 128'(1));
      check("t_beat", 128'(fill1_cyc - ack_cyc), 128'(2));
      check("t_done", 128'(done_cyc - ack_cyc), 128'(2 + LW));
    end
  endtask

  initial begin
    int nb_tab[6] = '{4, 4, 3, 5, 4, 2};
    logic dty, wbe;
    vectors          = 0;
    miscompares      = 0;
    cyc              = 0;
    rst              = 1'b1;
    miss_val         = 1'b0;
    miss_addr        = '0;
    miss_dirty       = 1'b0;
    miss_victim_addr = '0;
    vic_rdata        = '0;
    req_rdy          = 1'b0;
    resp_val         = 1'b0;
    resp_err         = 1'b0;
    resp_rdata_val   = 1'b0;
    resp_rdata       = '0;
    prev_rv          = 1'b0;
    prev_wv          = 1'b0;
    prev_rdy         = 1'b0;
    prev_cmd         = '0;
    prev_addr        = '0;
    prev_wd          = '0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_miss(16'h1234, 1'b0, 16'h0000, 4, 1'b0, 1'b0, 0, 1'b0, 1'b1);  // clean miss, best case
    do_miss(16'h1238, 1'b1, 16'h4560, 4, 1'b0, 1'b0, 1, 1'b0, 1'b0);  // dirty, rdy toggling
    do_miss(16'h2222, 1'b1, 16'h777c, 4, 1'b1, 1'b0, 0, 1'b0, 1'b0);  // writeback error
    do_miss(16'h3330, 1'b0, 16'h0000, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // short burst
    do_miss(16'h5555, 1'b0, 16'h0000, 5, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // surplus beat
    do_miss(16'h6a6f, 1'b1, 16'h9990, 4, 1'b0, 1'b0, 2, 1'b1, 1'b0);  // miss_val held high

    // Reset in the middle of a fill.
    clear_logs();
    miss_addr  = 16'hbeef;
    miss_dirty = 1'b0;
    miss_val   = 1'b1;
    req_rdy    = 1'b1;
    for (int c = 0; c < 20 && fi_q.size() < 2; c++) begin
      if (c > 0) miss_val = 1'b0;
      resp_rdata_val = (rq_cmd.size() > 0);
      resp_rdata     = $urandom();
      sample();
    end
    check("rst_pre_beats", 128'(fi_q.size()), 128'(2));
    resp_rdata_val = 1'b1;
    miss_val       = 1'b1;
    rst            = 1'b1;
    #1;
    check("rst_outs_now", all_outs(), 128'(0));
    @(posedge clk);
    #1;
    check("rst_outs_held", all_outs(), 128'(0));
    miss_val       = 1'b0;
    resp_rdata_val = 1'b0;
    rst            = 1'b0;
    prev_rv        = 1'b0;
    prev_wv        = 1'b0;
    do_miss(16'hbeef, 1'b0, 16'h0000, 4, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      dty = 1'($urandom());
      wbe = dty && ($urandom_range(4) == 0);
      do_miss(AW'($urandom()), dty, AW'($urandom()), nb_tab[t], wbe,
              ($urandom_range(4) == 0), 2, 1'($urandom()), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_refill_engine.md
# l1_refill_engine

Line refill/writeback engine between the L1 cache controller and the second-level cache interface. On a miss it writes back the dirty victim line, then fetches the missed line as a burst and writes each beat into the L1 data RAM. It also reports completion or error back to the controller. It sits directly downstream of the L1 controller and owns the `req_*`/`resp_*` L2 port.

## Interface
- `LINE_WORDS`, 4: words per cache line; power of two, ≥2.
- `ADDR_WIDTH`, 16: byte address width; matches `L2_ADDR_WIDTH`.
- `DATA_WIDTH`, 32: word width; matches `L2_DATA_WIDTH`.
- `L2_CMND_WIDTH`, 2: L2 command width.
- `L2_SIZE_WIDTH`, 3: L2 size field width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `miss_val` in 1: refill request from the L1 controller.
- `miss_addr` in ADDR_WIDTH: byte address of the missed access.
- `miss_dirty` in 1: victim line is dirty and must be written back.
- `miss_victim_addr` in ADDR_WIDTH: byte address of the victim line.
- `miss_ack` out 1: one-cycle pulse; request captured.
- `vic_ren` out 1: victim-word read strobe to the L1 data RAM.
- `vic_idx` out log2(LINE_WORDS): victim word index.
- `vic_rdata` in DATA_WIDTH: victim word, valid the cycle after `vic_ren`.
- `fill_wen` out 1: fill-word write strobe.
- `fill_idx` out log2(LINE_WORDS): fill word index.
- `fill_wdata` out DATA_WIDTH: fill word.
- `req_val`, `req_nc`, `req_cmd`, `req_size`, `req_addr`: L2 request channel. `req_nc` is always 0.
- `req_wdata_val`, `req_wdata`, `req_wstrb`: L2 write-data channel. `req_wstrb` is all ones whenever `req_wdata_val`=1.
- `req_rdy` in 1: L2 accepts the request or the write beat this cycle.
- `resp_val`, `resp_err`, `resp_rdata_val`, `resp_rdata`: L2 response inputs.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 means the fill data must not be validated.

## Operation
- L2 commands: `L2_CMD_RD`=2'b00, `L2_CMD_WR`=2'b01.
- `req_size` = log2(LINE_WORDS*4), which is 3'd4 for 16-byte lines.
- `req_addr` is line-aligned: the low log2(LINE_WORDS*4) bits are zeroed.
- States: IDLE, WB_READ, WB_REQ, WB_DATA, WB_RESP, RD_REQ, RD_DATA, DONE.
- IDLE:
  - on `miss_val`, pulse `miss_ack` and capture the addresses and the dirty flag;
  - go to WB_READ if dirty, else RD_REQ;
  - `miss_val` is ignored in every other state.
- WB_READ: issue `vic_ren` for idx 0..LINE_WORDS-1 on consecutive cycles and store each returned word in the line buffer. Enter WB_REQ after the last word lands.
- WB_REQ: hold `req_val`=1, `req_cmd`=WR and the victim address until `req_rdy`.
- WB_DATA: drive `req_wdata_val` with buffer word k. k advances only on `req_rdy`; after beat LINE_WORDS-1 go to WB_RESP.
- WB_RESP: wait for `resp_val`.
  - `resp_err`=1: set the error flag and go to DONE (the refill is skipped).
  - Otherwise: go to RD_REQ.
- RD_REQ: hold `req_val`=1, `req_cmd`=RD and the miss address until `req_rdy`.
- RD_DATA:
  - each `resp_rdata_val` produces `fill_wen`=1, `fill_idx`=beat count and `fill_wdata`=`resp_rdata` in the same cycle (combinational pass-through); the beat count then increments.
  - `resp_val` ends the state. It may coincide with the last beat, and that beat is still written.
  - `err` = `resp_err` OR (beat count including the current beat ≠ LINE_WORDS).
  - Beats beyond LINE_WORDS are dropped, with no `fill_wen`, and force `err`.
- DONE: `done`=1 and `err`=flag for one cycle, then IDLE with the flag cleared.

## Timing
- Reset values: every output is 0 and the state is IDLE. Counters and the error flag clear asynchronously.
- Reset mid-operation: abort immediately, with no further `fill_wen` or `req_val`. The L1 controller treats the line as invalid.
- `miss_ack` is asserted in the same cycle as `miss_val` in IDLE; the first request follows on the next cycle.
- Clean-miss best case (`req_rdy`=1, beats back-to-back, `resp_val` on the last beat): `miss_ack` at T0, `req_val` at T1, beats from T2, `done` at T2+LINE_WORDS.
- Dirty victim: adds LINE_WORDS+1 cycles of WB_READ, plus the request, data and response handshakes.
- `req_val`/`req_wdata_val` hold their values stable until accepted.
- `req_val` and `req_wdata_val` are never asserted in the same cycle.
- Beat and word counters are log2(LINE_WORDS) wide plus one overflow bit, so overflow is detectable.

## Structure
- Package `l1_cache_pkg`: L2 command enum, FSM state enum, `LINE_BYTES`/offset-width constants.
- Sub-module `l1_line_buffer`: LINE_WORDS×DATA_WIDTH register file with a write index and a read index.

## Test plan
- Clean miss: `miss_addr`=16'h1234, dirty=0.
  - Expect `req_addr`=16'h1230, `req_cmd`=RD, `req_size`=4.
  - L2 returns A0..A3, then `fill_wen` idx 0..3 with A0..A3.
  - `done`=1, `err`=0.
- Dirty miss: victim 16'h4560 holding D0..D3, `req_rdy` toggled 1-0-1.
  - Expect the WR request, then D0..D3 in order, each held while `req_rdy`=0.
  - Then the RD request; `done` with `err`=0.
- Writeback error: `resp_err`=1 in WB_RESP.
  - Expect no RD request and no `fill_wen`.
  - `done`=1, `err`=1.
- Short burst: 3 beats, then `resp_val`.
  - Expect 3 `fill_wen` (idx 0..2).
  - `done`=1, `err`=1.
- Assert `rst` during RD_DATA after 2 beats.
  - All outputs are 0 in the same cycle.
  - A new miss is handled normally after `rst` deasserts.
- `miss_val` held high throughout a refill: only one `miss_ack` per transaction.
